fmdll_lock_ctrl: RTL and testbench
==================================

FMDLL_LOCK_CTRL -- requirements
Module: fmdll_lock_ctrl

Interface
REQ-001 Parameter LOCK_CNT, default 4: consecutive quiet evaluations required to declare lock.
REQ-002 clk_ext  in  1  reference clock; all logic on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  one-cycle request to begin acquisition.
REQ-005 stop  in  1  abort to IDLE.
REQ-006 cfg_n  in  4  requested N; cfg_m  in  2  requested M; cfg_sel  in  1  requested Sel.
REQ-007 pd_up, pd_dn  in  1 each  phase-detector outputs, already synchronous to clk_ext; up = delay too short.
REQ-008 m_counter  in  2  M counter value from the clock counter.
REQ-009 N  out  4, M  out  2, Sel  out  1  latched configuration driving the clock counter.
REQ-010 coarse_code  out  4, fine_code  out  5  delay-line control codes.
REQ-011 locked, busy, err  out  1 each  status.

Function
REQ-012 States SHALL be IDLE, COARSE, FINE, LOCKED; busy = (state != IDLE).
REQ-013 tick SHALL be asserted in any non-IDLE cycle where m_counter == M; one evaluation per tick.
REQ-014 A tick SHALL be ignored if the immediately preceding evaluation changed either code (settle skip).
REQ-015 IDLE + start: if cfg_n == 0 or cfg_m == 0, set err=1 and stay IDLE; else latch N/M/Sel, coarse=0, fine=16, quiet=0, err=0, go COARSE next cycle.
REQ-016 start while busy SHALL be ignored; stop and start in the same cycle: stop wins.
REQ-017 stop in any state SHALL go IDLE next cycle, clear locked, and hold codes and N/M/Sel.
REQ-018 COARSE tick: up-only -> coarse+1; up-only with coarse == 15 -> err=1, IDLE; dn-only -> coarse-1 (saturate 0), go FINE; neither or both -> go FINE.
REQ-019 FINE tick: up-only -> fine+1; dn-only -> fine-1; any correction -> quiet=0.
REQ-020 FINE tick: neither or both -> quiet+1; quiet reaching LOCK_CNT -> LOCKED, locked=1.
REQ-021 Fine overflow (up at 31): fine=16, coarse+1; if coarse == 15 -> err=1, IDLE.
REQ-022 Fine underflow (dn at 0): fine=16, coarse-1; if coarse == 0 -> err=1, IDLE.
REQ-023 LOCKED tick: apply fine corrections per REQ-019 while keeping locked=1.
REQ-024 LOCKED: a fine overflow/underflow SHALL clear locked, apply REQ-021/022, and go FINE with quiet=0.
REQ-025 Code updates SHALL be registered: visible the cycle after the evaluating tick.

Reset
REQ-026 Reset SHALL force state=IDLE, N=1, M=1, Sel=0, coarse_code=0, fine_code=16, locked=0, busy=0, err=0, quiet=0, settle flag=0.
REQ-027 Reset mid-acquisition SHALL abandon it immediately; no output retains a pre-reset value.

Configuration
REQ-028 With FMDLL_LOCK_TIMEOUT_EN defined: an 8-bit counter SHALL count non-skipped ticks in COARSE/FINE, clearing on entry to LOCKED or IDLE.
REQ-029 Timeout count reaching 255 SHALL set err=1 and go IDLE.
REQ-030 Without FMDLL_LOCK_TIMEOUT_EN: no timeout counter exists; acquisition may run indefinitely.

Structure
REQ-031 Shared package fmdll_pkg SHALL hold: state enum, FINE_MID=16, CODE widths (4/5), N/M widths.
REQ-032 Saturating coarse/fine step logic with rollover flags SHALL be sub-module fmdll_code_step; FSM and tick logic stay in the top.

Verification
REQ-033 cfg_n=5, cfg_m=2, start -> N=5, M=2, busy=1, COARSE, coarse=0, fine=16.
REQ-034 cfg_m=0, start -> err=1, state IDLE, N/M unchanged.
REQ-035 pd_up held 3 evaluated ticks, then quiet -> coarse=3, FINE; LOCK_CNT=4 quiet ticks later -> locked=1; every tick after a change skipped.
REQ-036 In LOCKED with fine=31, pd_up -> fine=16, coarse+1, locked=0, FINE.
REQ-037 stop asserted with start in FINE -> IDLE next cycle, codes held, locked=0.
REQ-038 FMDLL_LOCK_TIMEOUT_EN, pd_up/pd_dn alternating forever -> err=1, IDLE after 255 evaluated ticks.

Source files
------------

// File: rtl/fmdll_pkg.sv
// fmdll_pkg: shared state type, code widths and fine-code midpoint for the FMDLL lock controller.
package fmdll_pkg;
    localparam int CW = 4;
    localparam int FW = 5;
    localparam int NW = 4;
    localparam int MW = 2;
    localparam logic [FW-1:0] FINE_MID = 5'd16;
    typedef enum logic [1:0] {IDLE, COARSE, FINE, LOCKED} state_e;
endpackage

// File: rtl/fmdll_code_step.sv
// fmdll_code_step: one saturating coarse/fine correction step with fine-rollover and coarse-range error flags.
module fmdll_code_step
    import fmdll_pkg::*;
(
    input  logic          fine_mode_i,
    input  logic          up_i,
    input  logic          dn_i,
    input  logic [CW-1:0] coarse_i,
    input  logic [FW-1:0] fine_i,
    output logic [CW-1:0] coarse_o,
    output logic [FW-1:0] fine_o,
    output logic          roll_o,
    output logic          err_o
);
    logic up_only, dn_only, c_max, c_min, f_max, f_min, c_up, c_dn;
    assign up_only = up_i & ~dn_i;
    assign dn_only = dn_i & ~up_i;
    assign c_max   = &coarse_i;
    assign c_min   = coarse_i == '0;
    assign f_max   = &fine_i;
    assign f_min   = fine_i == '0;
    assign roll_o  = fine_mode_i & ((up_only & f_max) | (dn_only & f_min));
    // Coarse moves directly in coarse mode, or as a carry/borrow out of the fine code.
    assign c_up    = up_only & (~fine_mode_i | f_max);
    assign c_dn    = dn_only & (~fine_mode_i | f_min);
    assign err_o   = (c_up & c_max) | (c_dn & c_min & fine_mode_i);
    assign coarse_o = err_o ? coarse_i :
                      c_up ? coarse_i + CW'(1) :
                      (c_dn & ~c_min) ? coarse_i - CW'(1) : coarse_i;
    assign fine_o   = (err_o | ~fine_mode_i) ? fine_i :
                      roll_o ? FINE_MID :
                      up_only ? fine_i + FW'(1) :
                      dn_only ? fine_i - FW'(1) : fine_i;
endmodule

// File: rtl/fmdll_lock_ctrl.sv
// fmdll_lock_ctrl: coarse/fine delay-line lock acquisition FSM for the FMDLL.
// Defining FMDLL_LOCK_TIMEOUT_EN aborts acquisition with err after 255 evaluations.
module fmdll_lock_ctrl
    import fmdll_pkg::*;
#(
    parameter int LOCK_CNT = 4
) (
    input  logic          clk_ext,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic [NW-1:0] cfg_n,
    input  logic [MW-1:0] cfg_m,
    input  logic          cfg_sel,
    input  logic          pd_up,
    input  logic          pd_dn,
    input  logic [MW-1:0] m_counter,
    output logic [NW-1:0] N,
    output logic [MW-1:0] M,
    output logic          Sel,
    output logic [CW-1:0] coarse_code,
    output logic [FW-1:0] fine_code,
    output logic          locked,
    output logic          busy,
    output logic          err
);
    localparam int QW = $clog2(LOCK_CNT + 1);
    state_e        state_q, state_d;
    logic [NW-1:0] n_q, n_d;
    logic [MW-1:0] m_q, m_d;
    logic          sel_q, sel_d, err_q, err_d, settle_q, settle_d;
    logic [CW-1:0] coarse_q, coarse_d, step_coarse;
    logic [FW-1:0] fine_q, fine_d, step_fine;
    logic [QW-1:0] quiet_q, quiet_d;
    logic          tick, corr, up_only, step_roll, step_err;
`ifdef FMDLL_LOCK_TIMEOUT_EN
    logic [7:0]    to_q, to_d;
`endif
    assign up_only = pd_up & ~pd_dn;
    assign corr    = pd_up ^ pd_dn;
    assign tick    = (state_q != IDLE) && (m_counter == m_q);
    fmdll_code_step u_step (
        .fine_mode_i (state_q != COARSE),
        .up_i        (pd_up),
        .dn_i        (pd_dn),
        .coarse_i    (coarse_q),
        .fine_i      (fine_q),
        .coarse_o    (step_coarse),
        .fine_o      (step_fine),
        .roll_o      (step_roll),
        .err_o       (step_err)
    );
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        m_d      = m_q;
        sel_d    = sel_q;
        coarse_d = coarse_q;
        fine_d   = fine_q;
        err_d    = err_q;
        quiet_d  = quiet_q;
        settle_d = settle_q;
        if (state_q == IDLE) begin
            if (start && !stop) begin
                if (cfg_n == '0 || cfg_m == '0) begin
                    err_d = 1'b1;
                end else begin
                    state_d  = COARSE;
                    n_d      = cfg_n;
                    m_d      = cfg_m;
                    sel_d    = cfg_sel;
                    coarse_d = '0;
                    fine_d   = FINE_MID;
                    quiet_d  = '0;
                    settle_d = 1'b0;
                    err_d    = 1'b0;
                end
            end
        end else if (stop) begin
            state_d  = IDLE;
            quiet_d  = '0;
            settle_d = 1'b0;
        end else if (tick && settle_q) begin
            settle_d = 1'b0;
        end else if (tick && step_err) begin
            state_d  = IDLE;
            err_d    = 1'b1;
            quiet_d  = '0;
            settle_d = 1'b0;
        end else if (tick) begin
            coarse_d = step_coarse;
            fine_d   = step_fine;
            settle_d = (step_coarse != coarse_q) || (step_fine != fine_q);
            if (state_q == COARSE) begin
                state_d = up_only ? COARSE : FINE;
            end else if (state_q == FINE) begin
                quiet_d = corr ? '0 : quiet_q + QW'(1);
                if (!corr && quiet_q + QW'(1) == QW'(LOCK_CNT)) begin
                    state_d = LOCKED;
                    quiet_d = '0;
                end
            end else if (step_roll) begin
                state_d = FINE;
                quiet_d = '0;
            end
        end
`ifdef FMDLL_LOCK_TIMEOUT_EN
        to_d = (state_d == IDLE || state_d == LOCKED) ? '0 :
               to_q + 8'(tick && !settle_q && state_q != LOCKED);
        if (to_d == 8'd255) begin
            state_d  = IDLE;
            err_d    = 1'b1;
            quiet_d  = '0;
            settle_d = 1'b0;
            to_d     = '0;
        end
`endif
    end
    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            n_q      <= NW'(1);
            m_q      <= MW'(1);
            sel_q    <= 1'b0;
            coarse_q <= '0;
            fine_q   <= FINE_MID;
            err_q    <= 1'b0;
            quiet_q  <= '0;
            settle_q <= 1'b0;
`ifdef FMDLL_LOCK_TIMEOUT_EN
            to_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            m_q      <= m_d;
            sel_q    <= sel_d;
            coarse_q <= coarse_d;
            fine_q   <= fine_d;
            err_q    <= err_d;
            quiet_q  <= quiet_d;
            settle_q <= settle_d;
`ifdef FMDLL_LOCK_TIMEOUT_EN
            to_q     <= to_d;
`endif
        end
    end
    assign N           = n_q;
    assign M           = m_q;
    assign Sel         = sel_q;
    assign coarse_code = coarse_q;
    assign fine_code   = fine_q;
    assign err         = err_q;
    assign locked      = state_q == LOCKED;
    assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_fmdll_lock_ctrl.sv
// tb_fmdll_lock_ctrl: directed vector table, corner sequences and randomized run against a behavioural model.
module tb_fmdll_lock_ctrl;
    localparam int LOCK_CNT = 4;
    logic clk_ext = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, cfg_sel = 1'b0, pd_up = 1'b0, pd_dn = 1'b0;
    logic [3:0] cfg_n = '0;
    logic [1:0] cfg_m = '0, m_counter = '0;
    logic [3:0] N, coarse_code;
    logic [1:0] M;
    logic [4:0] fine_code;
    logic Sel, locked, busy, err;
    int checks = 0, failures = 0;
    string ph;
    logic [3:0] mn;
    logic [1:0] mm;
    logic msel, merr, mset;
    int mc, mf, mq, mto;

    typedef struct {
        logic st, sp;
        logic [3:0] n;
        logic [1:0] m;
        logic sel, up, dn;
        logic [1:0] mc;
        logic [18:0] exp;
    } vec_t;

    always #5 clk_ext = ~clk_ext;

    fmdll_lock_ctrl #(.LOCK_CNT(LOCK_CNT)) dut (
        .clk_ext(clk_ext), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_sel(cfg_sel), .pd_up(pd_up), .pd_dn(pd_dn),
        .m_counter(m_counter), .N(N), .M(M), .Sel(Sel), .coarse_code(coarse_code),
        .fine_code(fine_code), .locked(locked), .busy(busy), .err(err)
    );

    function automatic logic [18:0] pk(int n, int m, int s, int c, int f, int l, int b, int e);
        return {4'(n), 2'(m), 1'(s), 4'(c), 5'(f), 1'(l), 1'(b), 1'(e)};
    endfunction

    function automatic vec_t mk(int st, int sp, int n, int m, int sel, int up, int dn, int mcv, logic [18:0] e);
        vec_t v;
        v.st = 1'(st); v.sp = 1'(sp); v.n = 4'(n); v.m = 2'(m); v.sel = 1'(sel);
        v.up = 1'(up); v.dn = 1'(dn); v.mc = 2'(mcv); v.exp = e;
        return v;
    endfunction

    task automatic check(string name, logic [18:0] exp);
        logic [18:0] act;
        act = {N, M, Sel, coarse_code, fine_code, locked, busy, err};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got N=%0d M=%0d Sel=%0d coarse=%0d fine=%0d locked=%0d busy=%0d err=%0d, want N=%0d M=%0d Sel=%0d coarse=%0d fine=%0d locked=%0d busy=%0d err=%0d",
                     name, act[18:15], act[14:13], act[12], act[11:8], act[7:3], act[2], act[1], act[0],
                     exp[18:15], exp[14:13], exp[12], exp[11:8], exp[7:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(logic st, logic sp, logic [3:0] n, logic [1:0] m, logic sel, logic up, logic dn, logic [1:0] mcv);
        start = st; stop = sp; cfg_n = n; cfg_m = m; cfg_sel = sel; pd_up = up; pd_dn = dn; m_counter = mcv;
        @(posedge clk_ext);
        #1;
    endtask

    function automatic void model_reset();
        ph = "IDLE"; mn = 4'd1; mm = 2'd1; msel = 1'b0; mc = 0; mf = 16; merr = 1'b0; mq = 0; mset = 1'b0; mto = 0;
    endfunction

    function automatic logic [18:0] model_exp();
        return pk(int'(mn), int'(mm), int'(msel), mc, mf, int'(ph == "LOCKED"), int'(ph != "IDLE"), int'(merr));
    endfunction

    // Expected state after one rising edge: the delay is nudged by one code step per evaluated tick.
    function automatic void model_step(logic st, logic sp, logic [3:0] n, logic [1:0] m, logic sel, logic up, logic dn, logic [1:0] mcv);
        int nc, nf;
        bit uo, dO, bad, roll;
        string prev;
        uo = up && !dn; dO = dn && !up; prev = ph;
        if (ph == "IDLE") begin
            if (st && !sp) begin
                if (n == 0 || m == 0) merr = 1'b1;
                else begin
                    mn = n; mm = m; msel = sel; mc = 0; mf = 16; mq = 0; mset = 1'b0; merr = 1'b0; ph = "COARSE";
                end
            end
        end else if (sp) begin
            ph = "IDLE"; mq = 0; mset = 1'b0; mto = 0;
        end else if (mcv == mm && mset) begin
            mset = 1'b0;
        end else if (mcv == mm) begin
            nc = mc; nf = mf; roll = 0;
            if (ph == "COARSE") begin
                if (uo) nc = mc + 1;
                else if (dO && mc > 0) nc = mc - 1;
            end else if (uo || dO) begin
                nf = mf + (uo ? 1 : -1);
                if (nf < 0 || nf > 31) begin
                    roll = 1; nf = 16; nc = mc + (uo ? 1 : -1);
                end
            end
            bad = nc < 0 || nc > 15;
            if (bad) begin
                ph = "IDLE"; merr = 1'b1; mq = 0; mset = 1'b0; mto = 0;
            end else begin
                mset = (nc != mc) || (nf != mf);
                mc = nc; mf = nf;
                if (ph == "COARSE") begin
                    if (!uo) ph = "FINE";
                end else if (ph == "FINE") begin
                    mq = (uo || dO) ? 0 : mq + 1;
                    if (mq == LOCK_CNT) begin ph = "LOCKED"; mq = 0; end
                end else if (roll) begin
                    ph = "FINE"; mq = 0;
                end
`ifdef FMDLL_LOCK_TIMEOUT_EN
                if (prev != "LOCKED") mto++;
                if (ph == "LOCKED") mto = 0;
                else if (mto == 255) begin
                    ph = "IDLE"; merr = 1'b1; mq = 0; mset = 1'b0; mto = 0;
                end
`endif
            end
        end
    endfunction

    initial begin
        vec_t tbl[18];
        logic [3:0] rn;
        logic [1:0] rm, rmc;
        logic rst_, rsp, rsel, rup, rdn;
        int r;
        tbl[0]  = mk(1,0,5,0,1,0,0,0, pk(1,1,0,0,16,0,0,1));
        tbl[1]  = mk(1,0,5,2,1,0,0,0, pk(5,2,1,0,16,0,1,0));
        tbl[2]  = mk(0,0,5,2,1,1,0,2, pk(5,2,1,1,16,0,1,0));
        tbl[3]  = mk(0,0,5,2,1,1,0,2, pk(5,2,1,1,16,0,1,0));
        tbl[4]  = mk(0,0,5,2,1,1,0,0, pk(5,2,1,1,16,0,1,0));
        tbl[5]  = mk(0,0,5,2,1,1,0,2, pk(5,2,1,2,16,0,1,0));
        tbl[6]  = mk(0,0,5,2,1,1,0,2, pk(5,2,1,2,16,0,1,0));
        tbl[7]  = mk(0,0,5,2,1,1,0,2, pk(5,2,1,3,16,0,1,0));
        tbl[8]  = mk(0,0,5,2,1,0,0,2, pk(5,2,1,3,16,0,1,0));
        tbl[9]  = mk(0,0,5,2,1,0,0,2, pk(5,2,1,3,16,0,1,0));
        tbl[10] = mk(0,0,5,2,1,1,1,2, pk(5,2,1,3,16,0,1,0));
        tbl[11] = mk(0,0,5,2,1,1,1,2, pk(5,2,1,3,16,0,1,0));
        tbl[12] = mk(0,0,5,2,1,0,0,2, pk(5,2,1,3,16,0,1,0));
        tbl[13] = mk(0,0,5,2,1,0,0,2, pk(5,2,1,3,16,1,1,0));
        tbl[14] = mk(1,0,7,3,0,0,0,0, pk(5,2,1,3,16,1,1,0));
        tbl[15] = mk(0,0,5,2,1,0,1,2, pk(5,2,1,3,15,1,1,0));
        tbl[16] = mk(0,0,5,2,1,0,1,2, pk(5,2,1,3,15,1,1,0));
        tbl[17] = mk(0,0,5,2,1,0,1,2, pk(5,2,1,3,14,1,1,0));
        #12;
        check("reset", pk(1,1,0,0,16,0,0,0));
        rst_n = 1'b1;
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].st, tbl[i].sp, tbl[i].n, tbl[i].m, tbl[i].sel, tbl[i].up, tbl[i].dn, tbl[i].mc);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end
        // Walk fine up to 31 while locked: each evaluation is followed by a skipped settle tick.
        for (int i = 0; i < 17; i++) begin
            drive(0,0,5,2,1,1,0,2);
            drive(0,0,5,2,1,1,0,2);
        end
        check("locked_fine_max", pk(5,2,1,3,31,1,1,0));
        drive(0,0,5,2,1,1,0,2);
        drive(0,0,5,2,1,1,0,2);
        check("locked_overflow", pk(5,2,1,4,16,0,1,0));
        drive(0,0,5,2,1,0,0,2);
        for (int i = 1; i <= 4; i++) begin
            drive(0,0,5,2,1,0,0,2);
            if (i == 3) check("relock_q3", pk(5,2,1,4,16,0,1,0));
        end
        check("relock_q4", pk(5,2,1,4,16,1,1,0));
        drive(0,0,5,2,1,0,1,2);
        drive(1,1,9,3,0,0,0,0);
        check("stop_beats_start", pk(5,2,1,4,15,0,0,0));
        drive(1,1,9,3,0,0,0,0);
        check("idle_stop_start", pk(5,2,1,4,15,0,0,0));
        drive(1,0,6,1,0,0,0,0);
        check("restart", pk(6,1,0,0,16,0,1,0));
        drive(0,0,6,1,0,1,0,1);
        check("coarse_step", pk(6,1,0,1,16,0,1,0));
        rst_n = 1'b0;
        #2;
        check("async_reset", pk(1,1,0,0,16,0,0,0));
        rst_n = 1'b1;
`ifdef FMDLL_LOCK_TIMEOUT_EN
        begin
            int cyc;
            drive(1,0,3,1,0,0,0,0);
            drive(0,0,3,1,0,1,1,1);
            cyc = 1;
            while (!err && cyc < 2000) begin
                drive(0,0,3,1,0, fine_code == 5'd16, fine_code != 5'd16, 1);
                cyc++;
            end
            checks++;
            if (cyc != 508) begin
                failures++;
                $display("FAIL timeout_cycles: got %0d cycles, want 508", cyc);
            end
            check("timeout_state", pk(3,1,0,0,16,0,0,1));
        end
`endif
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                rst_n = 1'b0;
                model_reset();
                #2;
                check("rand_reset", model_exp());
                rst_n = 1'b1;
            end
            rst_ = $urandom_range(0, 9) == 0;
            rsp = $urandom_range(0, 49) == 0;
            rn = 4'($urandom);
            rm = 2'($urandom);
            rsel = 1'($urandom);
            r = $urandom_range(0, 9);
            rup = r < 2 || r == 9;
            rdn = (r >= 2 && r < 4) || r == 9;
            rmc = 2'($urandom);
            model_step(rst_, rsp, rn, rm, rsel, rup, rdn, rmc);
            drive(rst_, rsp, rn, rm, rsel, rup, rdn, rmc);
            check($sformatf("rand%0d", i), model_exp());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
